lifo_fifo_buf: RTL and testbench
================================

// Module: lifo_fifo_buf
// PURPOSE
//  Parametrised on-chip buffer for the labelling/flood-fill datapath; one element per cycle.
//  Replaces the plain pointer stack: selectable LIFO/FIFO order, true full/empty at 2^ADDR_WIDTH
//  entries, and a registered show-ahead head word. Also adds an occupancy count, sticky error
//  flags, simultaneous push+pop, and a synchronous flush. Sits between the pixel scanner and the
//  label resolver.
// PARAMETERS
//  ADDR_WIDTH  8   log2 of storage depth; DEPTH = 1<<ADDR_WIDTH entries, all usable
//  DATA_WIDTH  32  element width in bits
//  MODE        0   0 = LIFO (stack), 1 = FIFO (queue); elaboration-time constant
// PORTS
//  clk        in   1             clock, all state updates on rising edge
//  reset_n    in   1             reset, synchronous, active-low
//  clear      in   1             synchronous flush; empties buffer, clears error flags
//  push       in   1             write data_in this cycle
//  pop        in   1             consume head element this cycle
//  data_in    in   DATA_WIDTH    element to write
//  data_out   out  DATA_WIDTH    current head (LIFO: top; FIFO: oldest); valid when empty==0
//  empty      out  1             count == 0
//  full       out  1             count == DEPTH
//  count      out  ADDR_WIDTH+1  occupancy, 0..DEPTH
//  overflow   out  1             sticky: push attempted while full without pop
//  underflow  out  1             sticky: pop attempted while empty
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): count=0, empty=1, full=0, data_out=0, overflow=0,
//   underflow=0. Memory contents are don't-care. Reset and clear override push/pop that cycle.
//  clear=1: same as reset for all outputs; takes priority over push/pop.
//  Show-ahead: data_out is a register holding the head element. After any accepted push/pop at
//   edge N, data_out/count/empty/full reflect the new state immediately after edge N.
//   No extra read cycle; pop is allowed every cycle back-to-back until empty.
//  Accepted operations per edge (eff_push = push & (~full | pop); eff_pop = pop & ~empty):
//   push only, not full  -> count+1; LIFO: head=data_in; FIFO: head unchanged unless was empty.
//   pop only, not empty  -> count-1; head = next element in order (LIFO: element below; FIFO:
//                           next oldest).
//   push+pop, not empty  -> count unchanged (also when full). LIFO: head replaced by data_in.
//                           FIFO: data_in enqueued at tail, head advances.
//   push+pop, empty      -> treated as push only; underflow set.
//   push, full, no pop   -> ignored, contents unchanged; overflow set.
//   pop, empty, no push  -> ignored; underflow set; data_out holds last value.
//  Flags are sticky until reset/clear. full/empty/count are registered, never combinational
//   from push/pop.
//  Pointers wrap modulo DEPTH (FIFO read/write pointers; LIFO single pointer). Occupancy is
//   tracked in the ADDR_WIDTH+1 bit count, so full and empty are never ambiguous.
//  Storage: a synchronous-read RAM cannot supply the next head in zero cycles. The design keeps
//   the head register plus a prefetched "next" register refilled from RAM. The RAM read address
//   is chosen so next is valid the cycle after any single op. Consecutive pops must still see
//   correct data. Read-during-write to the same address must return new data via an explicit
//   bypass mux.
// STRUCTURE
//  Package buf_pkg: MODE_LIFO=0, MODE_FIFO=1 localparams; op enum {OP_NONE, OP_PUSH, OP_POP,
//   OP_BOTH} derived from eff_push/eff_pop.
//  One sub-module: sdp_ram (simple dual-port, one write port, one sync-read port, parametrised
//   ADDR_WIDTH/DATA_WIDTH). All pointer, head/next, and flag logic stays in lifo_fifo_buf.
// TESTING (ADDR_WIDTH=2, DATA_WIDTH=8 unless noted; run each in both MODEs)
//  1 Reset mid-traffic: push 3 values, assert reset_n=0 one cycle -> count=0, empty=1,
//    data_out=0, flags=0.
//  2 Fill/drain: push 0x11,0x22,0x33,0x44 -> full=1, count=4. Then pop x4 on consecutive
//    cycles -> LIFO sees 44,33,22,11; FIFO sees 11,22,33,44; then empty=1.
//  3 Overflow: at full, push 0x55 -> overflow=1, count=4, contents unchanged. Drain order as in
//    test 2. Then clear -> overflow=0.
//  4 Underflow: on empty, pop -> underflow=1, count=0. Push+pop on empty with 0x66 ->
//    count=1, data_out=0x66.
//  5 Simultaneous at full: push+pop with 0x77. LIFO -> top=0x77, count=4.
//    FIFO -> head=0x22, 0x77 popped last.
//  6 Random push/pop 10k cycles, ADDR_WIDTH=4, vs. reference model: data_out, count, and flags
//    match every cycle.

Source files
------------

// File: rtl/lifo_fifo_buf_pkg.sv
// Shared constants and operation decode for the lifo_fifo_buf storage block.
package buf_pkg;

  localparam int MODE_LIFO = 0;
  localparam int MODE_FIFO = 1;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_BOTH
  } op_e;

  // Classifies the accepted (already qualified) push/pop pair of a cycle.
  function automatic op_e op_decode(input logic eff_push, input logic eff_pop);
    op_e op;
    case ({eff_push, eff_pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/lifo_fifo_buf_if.sv
// Handshake bundle between the pixel scanner / label resolver and the buffer.
interface lifo_fifo_buf_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic                  clear;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, push, pop, data_in,
    input  data_out, empty, full, count, overflow, underflow
  );

  modport slave (
    input  clear, push, pop, data_in,
    output data_out, empty, full, count, overflow, underflow
  );

endinterface

// File: rtl/lifo_fifo_buf_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-first).
module sdp_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // A same-address read returns the old word; the caller bypasses it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lifo_fifo_buf.sv
// LIFO/FIFO element buffer with registered show-ahead head, occupancy count and sticky
// error flags; the RAM read port keeps a prefetched "next" word ready behind the head.
module lifo_fifo_buf
  import buf_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MODE       = MODE_LIFO
) (
  input  logic            clk,
  input  logic            reset_n,
  lifo_fifo_buf_if.slave  bus
);

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam cnt_t FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam bit   IS_FIFO  = (MODE == MODE_FIFO);

  cnt_t  count_q, count_d;
  logic  empty_q, empty_d;
  logic  full_q, full_d;
  logic  ovf_q, ovf_d;
  logic  unf_q, unf_d;
  ptr_t  sp_q, sp_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  ptr_t  wr_ptr_q, wr_ptr_d;
  word_t head_q, head_d;
  logic  byp_q, byp_d;
  word_t byp_data_q, byp_data_d;

  logic  flush;
  logic  eff_push;
  logic  eff_pop;
  op_e   op;
  logic  ram_we;
  ptr_t  ram_waddr;
  ptr_t  ram_raddr;
  word_t ram_rd_data;
  word_t next_word;
  logic  last_elem;

  assign flush     = ~reset_n | bus.clear;
  assign eff_push  = bus.push & (~full_q | bus.pop);
  assign eff_pop   = bus.pop & ~empty_q;
  assign op        = op_decode(eff_push, eff_pop);
  assign last_elem = (count_q == cnt_t'(1));

  // The element directly behind the head; a write to the address read at the same edge
  // lands in the bypass register instead of the RAM output.
  assign next_word = byp_q ? byp_data_q : ram_rd_data;

  always_comb begin
    count_d    = count_q;
    sp_d       = sp_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    head_d     = head_q;
    ovf_d      = ovf_q | (bus.push & full_q & ~bus.pop);
    unf_d      = unf_q | (bus.pop & empty_q);
    ram_waddr  = IS_FIFO ? wr_ptr_q : sp_q;
    ram_we     = eff_push & ~flush;
    byp_data_d = bus.data_in;

    case (op)
      OP_PUSH: begin
        count_d = count_q + cnt_t'(1);
        if (IS_FIFO) begin
          wr_ptr_d = wr_ptr_q + ptr_t'(1);
          if (empty_q) begin
            head_d = bus.data_in;
          end
        end else begin
          sp_d   = sp_q + ptr_t'(1);
          head_d = bus.data_in;
        end
      end
      OP_POP: begin
        count_d = count_q - cnt_t'(1);
        if (IS_FIFO) begin
          rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end else begin
          sp_d = sp_q - ptr_t'(1);
        end
        // Popping the last element leaves the old head visible.
        if (!last_elem) begin
          head_d = next_word;
        end
      end
      OP_BOTH: begin
        if (IS_FIFO) begin
          wr_ptr_d = wr_ptr_q + ptr_t'(1);
          rd_ptr_d = rd_ptr_q + ptr_t'(1);
          head_d   = last_elem ? bus.data_in : next_word;
        end else begin
          ram_waddr = sp_q - ptr_t'(1);
          head_d    = bus.data_in;
        end
      end
      default: ;
    endcase

    if (flush) begin
      count_d  = '0;
      sp_d     = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      head_d   = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end

    // Prefetch the element that will sit behind the new head.
    ram_raddr = IS_FIFO ? (rd_ptr_d + ptr_t'(1)) : (sp_d - ptr_t'(2));
    byp_d     = ram_we & (ram_waddr == ram_raddr);

    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk) begin
    count_q    <= count_d;
    empty_q    <= empty_d;
    full_q     <= full_d;
    ovf_q      <= ovf_d;
    unf_q      <= unf_d;
    sp_q       <= sp_d;
    rd_ptr_q   <= rd_ptr_d;
    wr_ptr_q   <= wr_ptr_d;
    head_q     <= head_d;
    byp_q      <= byp_d;
    byp_data_q <= byp_data_d;
  end

  sdp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (bus.data_in),
    .rd_addr (ram_raddr),
    .rd_data (ram_rd_data)
  );

  assign bus.data_out  = head_q;
  assign bus.count     = count_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Bench: four buffers (depth 4 / 16, LIFO / FIFO) on shared stimulus, checked each cycle
// against a list-based model, plus literal expectations for the directed scenarios.
module tb_lifo_fifo_buf;

  localparam int NDUT = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       push;
  logic       pop;
  logic [7:0] din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lifo_fifo_buf_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus_l2 ();
  lifo_fifo_buf_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus_f2 ();
  lifo_fifo_buf_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus_l4 ();
  lifo_fifo_buf_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus_f4 ();

  assign bus_l2.clear = clear; assign bus_l2.push = push; assign bus_l2.pop = pop; assign bus_l2.data_in = din;
  assign bus_f2.clear = clear; assign bus_f2.push = push; assign bus_f2.pop = pop; assign bus_f2.data_in = din;
  assign bus_l4.clear = clear; assign bus_l4.push = push; assign bus_l4.pop = pop; assign bus_l4.data_in = din;
  assign bus_f4.clear = clear; assign bus_f4.push = push; assign bus_f4.pop = pop; assign bus_f4.data_in = din;

  lifo_fifo_buf #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .MODE(0)) u_l2 (.clk(clk), .reset_n(reset_n), .bus(bus_l2));
  lifo_fifo_buf #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .MODE(1)) u_f2 (.clk(clk), .reset_n(reset_n), .bus(bus_f2));
  lifo_fifo_buf #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .MODE(0)) u_l4 (.clk(clk), .reset_n(reset_n), .bus(bus_l4));
  lifo_fifo_buf #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .MODE(1)) u_f4 (.clk(clk), .reset_n(reset_n), .bus(bus_f4));

  // Model: lst[k][0] is the head; LIFO pushes at the front, FIFO appends at the back.
  logic [7:0] lst    [NDUT][16];
  int         n_m    [NDUT];
  logic [7:0] dout_m [NDUT];
  bit         ovf_m  [NDUT];
  bit         unf_m  [NDUT];

  function automatic int depth_of(input int k);
    return (k < 2) ? 4 : 16;
  endfunction

  function automatic bit is_fifo(input int k);
    return (k % 2) == 1;
  endfunction

  task automatic model_step(input int k);
    bit m_full;
    bit m_empty;
    bit epush;
    bit epop;
    if (!reset_n || clear) begin
      n_m[k] = 0; dout_m[k] = 8'h00; ovf_m[k] = 1'b0; unf_m[k] = 1'b0;
      return;
    end
    m_full  = (n_m[k] == depth_of(k));
    m_empty = (n_m[k] == 0);
    if (push && m_full && !pop) ovf_m[k] = 1'b1;
    if (pop && m_empty) unf_m[k] = 1'b1;
    epush = push && (!m_full || pop);
    epop  = pop && !m_empty;
    if (epop) begin
      for (int i = 0; i < 15; i++) lst[k][i] = lst[k][i+1];
      n_m[k]--;
    end
    if (epush) begin
      if (is_fifo(k)) begin
        lst[k][n_m[k]] = din;
      end else begin
        for (int i = 15; i > 0; i--) lst[k][i] = lst[k][i-1];
        lst[k][0] = din;
      end
      n_m[k]++;
    end
    if (n_m[k] > 0) dout_m[k] = lst[k][0];
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) model_step(k);
  end

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic cmp_dut(input int k, input logic [7:0] d, input logic [4:0] c,
                         input logic e, input logic f, input logic o, input logic u);
    check("data_out",  k, 32'(d), 32'(dout_m[k]));
    check("count",     k, 32'(c), 32'(n_m[k]));
    check("empty",     k, 32'(e), 32'(n_m[k] == 0));
    check("full",      k, 32'(f), 32'(n_m[k] == depth_of(k)));
    check("overflow",  k, 32'(o), 32'(ovf_m[k]));
    check("underflow", k, 32'(u), 32'(unf_m[k]));
  endtask

  always @(negedge clk) begin
    cmp_dut(0, bus_l2.data_out, 5'(bus_l2.count), bus_l2.empty, bus_l2.full, bus_l2.overflow, bus_l2.underflow);
    cmp_dut(1, bus_f2.data_out, 5'(bus_f2.count), bus_f2.empty, bus_f2.full, bus_f2.overflow, bus_f2.underflow);
    cmp_dut(2, bus_l4.data_out, 5'(bus_l4.count), bus_l4.empty, bus_l4.full, bus_l4.overflow, bus_l4.underflow);
    cmp_dut(3, bus_f4.data_out, 5'(bus_f4.count), bus_f4.empty, bus_f4.full, bus_f4.overflow, bus_f4.underflow);
  end

  task automatic drive(input bit p, input bit q, input logic [7:0] d, input bit c);
    push = p; pop = q; din = d; clear = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0;
  endtask

  task automatic fill4();
    drive(1'b1, 1'b0, 8'h11, 1'b0);
    drive(1'b1, 1'b0, 8'h22, 1'b0);
    drive(1'b1, 1'b0, 8'h33, 1'b0);
    drive(1'b1, 1'b0, 8'h44, 1'b0);
  endtask

  // Pops four times, checking the head of each depth-4 buffer before every pop.
  task automatic drain4(input logic [31:0] seq_l, input logic [31:0] seq_f, input string nm);
    for (int i = 0; i < 4; i++) begin
      check(nm, 0, 32'(bus_l2.data_out), 32'(seq_l[31-8*i -: 8]));
      check(nm, 1, 32'(bus_f2.data_out), 32'(seq_f[31-8*i -: 8]));
      drive(1'b0, 1'b1, 8'h00, 1'b0);
    end
    check("drained_empty", 0, 32'(bus_l2.empty), 32'd1);
    check("drained_empty", 1, 32'(bus_f2.empty), 32'd1);
  endtask

  initial begin
    logic [31:0] ord_l;
    logic [31:0] ord_f;
    int          ph;
    reset_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset in the middle of traffic
    drive(1'b1, 1'b0, 8'hA1, 1'b0);
    drive(1'b1, 1'b0, 8'hA2, 1'b0);
    drive(1'b1, 1'b0, 8'hA3, 1'b0);
    check("pre_reset_head", 0, 32'(bus_l2.data_out), 32'hA3);
    check("pre_reset_head", 1, 32'(bus_f2.data_out), 32'hA1);
    check("pre_reset_count", 0, 32'(bus_l2.count), 32'd3);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("reset_count", 0, 32'(bus_l2.count), 32'd0);
    check("reset_count", 1, 32'(bus_f2.count), 32'd0);
    check("reset_empty", 0, 32'(bus_l2.empty), 32'd1);
    check("reset_data",  1, 32'(bus_f2.data_out), 32'd0);
    check("reset_data",  0, 32'(bus_l2.data_out), 32'd0);
    check("reset_flags", 1, 32'({bus_f2.overflow, bus_f2.underflow}), 32'd0);

    // Fill and drain
    ord_l = 32'h44332211;
    ord_f = 32'h11223344;
    fill4();
    check("fill_full",  0, 32'(bus_l2.full), 32'd1);
    check("fill_full",  1, 32'(bus_f2.full), 32'd1);
    check("fill_count", 1, 32'(bus_f2.count), 32'd4);
    drain4(ord_l, ord_f, "drain_order");

    // Overflow at full, then clear
    fill4();
    drive(1'b1, 1'b0, 8'h55, 1'b0);
    check("ovf_flag",  0, 32'(bus_l2.overflow), 32'd1);
    check("ovf_flag",  1, 32'(bus_f2.overflow), 32'd1);
    check("ovf_count", 0, 32'(bus_l2.count), 32'd4);
    drain4(ord_l, ord_f, "ovf_drain_order");
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("clear_ovf", 0, 32'(bus_l2.overflow), 32'd0);
    check("clear_ovf", 1, 32'(bus_f2.overflow), 32'd0);

    // Underflow, then push+pop on empty
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    check("unf_flag",  0, 32'(bus_l2.underflow), 32'd1);
    check("unf_flag",  1, 32'(bus_f2.underflow), 32'd1);
    check("unf_count", 1, 32'(bus_f2.count), 32'd0);
    drive(1'b1, 1'b1, 8'h66, 1'b0);
    check("pp_empty_count", 0, 32'(bus_l2.count), 32'd1);
    check("pp_empty_data",  0, 32'(bus_l2.data_out), 32'h66);
    check("pp_empty_data",  1, 32'(bus_f2.data_out), 32'h66);
    drive(1'b0, 1'b0, 8'h00, 1'b1);

    // Push+pop at full
    fill4();
    drive(1'b1, 1'b1, 8'h77, 1'b0);
    check("pp_full_head",  0, 32'(bus_l2.data_out), 32'h77);
    check("pp_full_head",  1, 32'(bus_f2.data_out), 32'h22);
    check("pp_full_count", 0, 32'(bus_l2.count), 32'd4);
    check("pp_full_count", 1, 32'(bus_f2.count), 32'd4);
    drain4(32'h77332211, 32'h22334477, "pp_full_drain");
    drive(1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic in alternating fill-heavy / drain-heavy phases
    for (int cyc = 0; cyc < 10000; cyc++) begin
      ph      = (cyc / 48) % 2;
      push    = ($urandom_range(0, 99) < ((ph == 0) ? 75 : 30));
      pop     = ($urandom_range(0, 99) < ((ph == 0) ? 30 : 75));
      din     = 8'($urandom);
      clear   = ($urandom_range(0, 299) == 0);
      reset_n = ($urandom_range(0, 999) != 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
    end
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
